// File: rtl/gpio_input_ctrl.sv
// Purpose : GPIO header input front end: synchronises the fire button and the eight
//           answer pins, debounces the button, latches the answer byte per press.
// Latency : pin first sampled high at edge k -> btn_level and press event at edge
//           k+1+DEBOUNCE_CYCLES; release path has the same latency.
// Backpressure: one-deep mailbox; a press arriving while it is full and unacknowledged
//           keeps the oldest byte and raises overflow until the next rd_ack.
//
// Ports:
//   clk          system clock (50 MHz)
//   rst          synchronous, active-high reset
//   gpio1[40:1]  raw asynchronous header pins (37 = fire button, 8 scattered data pins)
//   rd_ack       CPU read acknowledge, single-cycle pulse
//   data_out     latched answer byte
//   data_valid   mailbox holds an unread byte
//   overflow     a press was dropped while the mailbox was full
//   btn_level    debounced fire-button level
//   press_count  total debounced presses, wraps 255 -> 0
module gpio_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [40:1] gpio1,
    input  logic        rd_ack,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        overflow,
    output logic        btn_level,
    output logic [7:0]  press_count
);

    // ------------------------------------------------------------------
    // Debounce FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // The edge that moves the FSM out of a stable state has already seen the
    // new synchronised level once, so the wait states only need to observe it
    // DEBOUNCE_CYCLES-1 more times. Counting 0..DEBOUNCE_CYCLES-2 in the wait
    // state gives exactly DEBOUNCE_CYCLES consecutive synchronised samples,
    // i.e. the event lands on edge k+1+DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    // ------------------------------------------------------------------
    // Pin map: answer byte bits are scattered across the header
    // ------------------------------------------------------------------
    logic [7:0] pin_byte;

    always_comb begin
        pin_byte    = 8'h00;
        pin_byte[7] = gpio1[35];
        pin_byte[6] = gpio1[21];
        pin_byte[5] = gpio1[33];
        pin_byte[4] = gpio1[23];
        pin_byte[3] = gpio1[31];
        pin_byte[2] = gpio1[25];
        pin_byte[1] = gpio1[39];
        pin_byte[0] = gpio1[27];
    end

    // Remaining header pins are not used by this block.
    logic unused_pins;
    assign unused_pins = &{1'b0, gpio1[20:1], gpio1[22], gpio1[24], gpio1[26],
                           gpio1[30:28], gpio1[32], gpio1[34], gpio1[36],
                           gpio1[38], gpio1[40]};

    // ------------------------------------------------------------------
    // Two-flop synchronisers (button and data byte)
    // ------------------------------------------------------------------
    logic       btn_s1;
    logic       btn_s2;
    logic [7:0] dat_s1;
    logic [7:0] dat_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            dat_s1 <= 8'h00;
            dat_s2 <= 8'h00;
        end else begin
            btn_s1 <= gpio1[37];
            btn_s2 <= btn_s1;
            dat_s1 <= pin_byte;
            dat_s2 <= dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             press_evt;

    assign cnt_done  = (cnt == CNT_LAST);
    // Press event is the PRESS_WAIT -> PRESSED transition.
    assign press_evt = (state == PRESS_WAIT) && btn_s2 && cnt_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RELEASED;
            cnt       <= '0;
            btn_level <= 1'b0;
        end else begin
            case (state)
                RELEASED: begin
                    if (btn_s2) begin
                        cnt   <= '0;
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s2) begin
                        // bounce: abandon and restart from scratch on next rise
                        cnt   <= '0;
                        state <= RELEASED;
                    end else if (cnt_done) begin
                        state     <= PRESSED;
                        btn_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s2) begin
                        cnt   <= '0;
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s2) begin
                        state <= PRESSED;
                    end else if (cnt_done) begin
                        state     <= RELEASED;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= RELEASED;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mailbox and press counter
    // ------------------------------------------------------------------
    // An ack on the same edge as a press frees the slot for the new byte, so
    // the press is accepted rather than counted as an overflow.
    logic slot_free;
    assign slot_free = !data_valid || rd_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            overflow    <= 1'b0;
            press_count <= 8'h00;
        end else begin
            if (press_evt) begin
                press_count <= press_count + 8'd1;
                if (slot_free) begin
                    data_out   <= dat_s2;
                    data_valid <= 1'b1;
                    if (rd_ack) begin
                        overflow <= 1'b0;
                    end
                end else begin
                    overflow <= 1'b1;
                end
            end else if (rd_ack && data_valid) begin
                data_valid <= 1'b0;
                overflow   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Purpose : self-checking bench for gpio_input_ctrl with DEBOUNCE_CYCLES=8.
// Latency : press/release expected on the 10th edge after the pin is driven.
// Backpressure: mailbox full/overflow/ack paths driven from a vector table.
module tb_gpio_input_ctrl;

    localparam int DB = 8;

    logic        clk;
    logic        rst;
    logic [40:1] gpio1;
    logic        rd_ack;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        overflow;
    logic        btn_level;
    logic [7:0]  press_count;

    int errors;
    int checks;

    gpio_input_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio1       (gpio1),
        .rd_ack      (rd_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .overflow    (overflow),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pins_byte;
        bit         ack_evt;   // rd_ack pulsed on the press-event edge
        bit         ack_after; // rd_ack pulsed after the button settles
        logic [7:0] exp_data;
        bit         exp_vld;
        bit         exp_ovf;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_byte(input logic [7:0] b);
        gpio1[35] = b[7];
        gpio1[21] = b[6];
        gpio1[33] = b[5];
        gpio1[23] = b[4];
        gpio1[31] = b[3];
        gpio1[25] = b[2];
        gpio1[39] = b[1];
        gpio1[27] = b[0];
    endtask

    task automatic check_idle(input string name);
        check({name, ".data_out"},    32'(data_out),    32'h0);
        check({name, ".data_valid"},  32'(data_valid),  32'h0);
        check({name, ".overflow"},    32'(overflow),    32'h0);
        check({name, ".btn_level"},   32'(btn_level),   32'h0);
        check({name, ".press_count"}, 32'(press_count), 32'h0);
    endtask

    // Raise the button and check btn_level rises on exactly the 10th edge.
    task automatic press_exact(input string name);
        gpio1[37] = 1'b1;
        ticks(DB + 1);
        check({name, ".early"}, 32'(btn_level), 32'h0);
        tick();
        check({name, ".on_time"}, 32'(btn_level), 32'h1);
    endtask

    task automatic release_settle();
        gpio1[37] = 1'b0;
        ticks(DB + 4);
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //                 byte  aEv aAf data  vld ovf cnt
        vecs[0] = '{8'h3a, 1'b0, 1'b0, 8'h3a, 1'b1, 1'b0, 8'd3};
        vecs[1] = '{8'h55, 1'b0, 1'b1, 8'h3a, 1'b1, 1'b1, 8'd4};
        vecs[2] = '{8'ha5, 1'b0, 1'b0, 8'ha5, 1'b1, 1'b0, 8'd5};
        vecs[3] = '{8'hc3, 1'b1, 1'b0, 8'hc3, 1'b1, 1'b0, 8'd6};
        vecs[4] = '{8'h0f, 1'b0, 1'b0, 8'hc3, 1'b1, 1'b1, 8'd7};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 8'd8};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'd9};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 8'd10};

        // Unused pins held high to show they are ignored.
        gpio1  = '1;
        rd_ack = 1'b0;
        set_byte(8'h00);

        // Reset with button held high.
        gpio1[37] = 1'b1;
        rst = 1'b1;
        ticks(3);
        check_idle("reset");
        rst = 1'b0;
        ticks(DB + 1);
        check("post_reset.early", 32'(btn_level), 32'h0);
        tick();
        check("post_reset.on_time", 32'(btn_level), 32'h1);
        check("post_reset.count", 32'(press_count), 32'd1);
        check("post_reset.valid", 32'(data_valid), 32'h1);

        // Clean restart.
        gpio1[37] = 1'b0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();

        // Basic press with byte fc, exact rise and release latency.
        set_byte(8'hfc);
        ticks(3);
        press_exact("basic");
        check("basic.data_out", 32'(data_out), 32'hfc);
        check("basic.valid", 32'(data_valid), 32'h1);
        check("basic.count", 32'(press_count), 32'd1);
        gpio1[37] = 1'b0;
        ticks(DB + 1);
        check("release.early", 32'(btn_level), 32'h1);
        tick();
        check("release.on_time", 32'(btn_level), 32'h0);
        ack_pulse();
        check("basic_ack.valid", 32'(data_valid), 32'h0);
        check("basic_ack.ovf", 32'(overflow), 32'h0);

        // Glitch of 5 cycles: no event.
        gpio1[37] = 1'b1;
        ticks(5);
        gpio1[37] = 1'b0;
        ticks(20);
        check("glitch.btn", 32'(btn_level), 32'h0);
        check("glitch.count", 32'(press_count), 32'd1);
        check("glitch.valid", 32'(data_valid), 32'h0);

        // Bounce 1-0-1 inside PRESS_WAIT restarts the count.
        gpio1[37] = 1'b1;
        ticks(4);
        gpio1[37] = 1'b0;
        ticks(2);
        press_exact("bounce");
        check("bounce.count", 32'(press_count), 32'd2);
        check("bounce.data_out", 32'(data_out), 32'hfc);
        release_settle();
        ack_pulse();

        // Mailbox behaviour from the vector table.
        for (int v = 0; v < 8; v++) begin
            set_byte(vecs[v].pins_byte);
            ticks(3);
            gpio1[37] = 1'b1;
            ticks(DB + 1);
            rd_ack = vecs[v].ack_evt;
            tick();
            rd_ack = 1'b0;
            check($sformatf("vec%0d.data_out", v), 32'(data_out),    32'(vecs[v].exp_data));
            check($sformatf("vec%0d.valid", v),    32'(data_valid),  32'(vecs[v].exp_vld));
            check($sformatf("vec%0d.overflow", v), 32'(overflow),    32'(vecs[v].exp_ovf));
            check($sformatf("vec%0d.count", v),    32'(press_count), 32'(vecs[v].exp_cnt));
            release_settle();
            if (vecs[v].ack_after) begin
                ack_pulse();
                check($sformatf("vec%0d.ack_valid", v), 32'(data_valid), 32'h0);
                check($sformatf("vec%0d.ack_ovf", v),   32'(overflow),   32'h0);
            end
        end

        // Wrap: 10 presses so far, 245 more -> 255, then one more -> 0.
        for (int p = 0; p < 245; p++) begin
            gpio1[37] = 1'b1;
            ticks(DB + 2);
            gpio1[37] = 1'b0;
            ticks(DB + 2);
        end
        check("wrap.count_255", 32'(press_count), 32'd255);
        gpio1[37] = 1'b1;
        ticks(DB + 2);
        check("wrap.count_0", 32'(press_count), 32'd0);
        release_settle();

        // Reset in the middle of PRESS_WAIT.
        gpio1[37] = 1'b1;
        ticks(5);
        rst = 1'b1;
        gpio1[37] = 1'b0;
        tick();
        rst = 1'b0;
        check_idle("mid_reset");
        ticks(15);
        check("mid_reset.no_evt_btn", 32'(btn_level), 32'h0);
        check("mid_reset.no_evt_count", 32'(press_count), 32'd0);
        set_byte(8'h5a);
        ticks(3);
        press_exact("after_reset");
        check("after_reset.count", 32'(press_count), 32'd1);
        check("after_reset.data_out", 32'(data_out), 32'h5a);
        release_settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
